// File: rtl/cvs_pkg.sv
// Shared types and constants for the five-channel edge monitor.
package cvs_pkg;

  localparam int unsigned NUM_CH = 5;
  localparam int unsigned CH_W   = 3;

  typedef logic [CH_W-1:0] ch_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam ch_idx_t LAST_CH = ch_idx_t'(NUM_CH - 1);

endpackage

// File: rtl/cvs_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for one async input.
module cvs_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_edge_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_edge_c = r_sync & ~r_prev;

endmodule

// File: rtl/cvs_edge_monitor.sv
// Counts rising edges on five async channels over a fixed gate, then reports
// one ready/valid beat per channel followed by a done pulse.
module cvs_edge_monitor
  import cvs_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 300000,
  parameter int unsigned COUNT_W     = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  channel_in,
  input  logic               start,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output ch_idx_t            result_channel,
  output logic [COUNT_W-1:0] result_count,
  output logic               result_overflow,
  output logic               done
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  state_t             r_state;
  logic [GATE_W-1:0]  r_gate;
  logic [COUNT_W-1:0] r_cnt [NUM_CH];
  logic [NUM_CH-1:0]  r_ovf;

  logic [NUM_CH-1:0]  w_edge;
  logic [COUNT_W-1:0] w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]  w_ovf_nxt;
  ch_idx_t            w_next_ch;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    cvs_edge_sync u_sync (
      .i_clk    (clock),
      .i_rst    (reset),
      .i_async  (channel_in[g]),
      .o_edge_c (w_edge[g])
    );
  end

  // Saturating increment; the sticky flag records any edge lost at full scale.
  always_comb begin
    w_ovf_nxt = r_ovf;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      w_cnt_nxt[ch] = r_cnt[ch];
      if (w_edge[ch]) begin
        if (r_cnt[ch] == '1) begin
          w_ovf_nxt[ch] = 1'b1;
        end else begin
          w_cnt_nxt[ch] = r_cnt[ch] + COUNT_W'(1);
        end
      end
    end
  end

  assign w_next_ch = result_channel + ch_idx_t'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_gate          <= '0;
      r_ovf           <= '0;
      busy            <= 1'b0;
      result_valid    <= 1'b0;
      result_channel  <= '0;
      result_count    <= '0;
      result_overflow <= 1'b0;
      done            <= 1'b0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) r_cnt[ch] <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) r_cnt[ch] <= '0;
            r_ovf   <= '0;
            r_gate  <= GATE_W'(GATE_CYCLES - 1);
            busy    <= 1'b1;
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          for (int unsigned ch = 0; ch < NUM_CH; ch++) r_cnt[ch] <= w_cnt_nxt[ch];
          r_ovf <= w_ovf_nxt;
          // Last gate cycle still counts, so the first beat uses next-state values.
          if (r_gate == '0) begin
            r_state         <= ST_REPORT;
            result_valid    <= 1'b1;
            result_channel  <= '0;
            result_count    <= w_cnt_nxt[0];
            result_overflow <= w_ovf_nxt[0];
          end else begin
            r_gate <= r_gate - GATE_W'(1);
          end
        end
        ST_REPORT: begin
          if (result_ready) begin
            if (result_channel == LAST_CH) begin
              r_state         <= ST_IDLE;
              result_valid    <= 1'b0;
              busy            <= 1'b0;
              done            <= 1'b1;
              result_channel  <= '0;
              result_count    <= '0;
              result_overflow <= 1'b0;
            end else begin
              result_channel  <= w_next_ch;
              result_count    <= r_cnt[w_next_ch];
              result_overflow <= r_ovf[w_next_ch];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
